// File: rtl/seq_red_and_pkg.sv
// Shared types and width helpers for the chunk-serial AND reduction.
package seq_red_and_pkg;

  // ACCUM: taking beats of the current frame. HOLD: presenting the result.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // $clog2 with a floor of 1 so that degenerate sizes still yield a real bus.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = $clog2(v);
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_red_and_first_zero_enc.sv
// Priority encoder on the inverted beat: position of the lowest zero bit.
module first_zero_enc
  import seq_red_and_pkg::*;
#(
  parameter int unsigned width = 8,
  localparam int unsigned posW = clog2_min1(width)
) (
  input  logic [width-1:0] a,
  output logic [posW-1:0]  pos,
  output logic             any_zero
);

  // Scan from the top down so the lowest zero wins.
  always_comb begin
    pos      = '0;
    any_zero = 1'b0;
    for (int i = width - 1; i >= 0; i--) begin
      if (!a[i]) begin
        pos      = posW'(i);
        any_zero = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_red_and.sv
// Chunk-serial AND reduction over framed beats, with lowest-zero index,
// saturating beat count and overflow flag; one result per frame.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
// are both high. in_ready_o is high only in ACCUM, out_valid_o only in HOLD,
// so the block never accepts a beat while a result is pending. The result
// registers are written only on the accepted last beat and stay frozen for
// the whole HOLD period.
module seq_red_and
  import seq_red_and_pkg::*;
#(
  parameter int unsigned width     = 8,
  parameter int unsigned maxChunks = 16,
  localparam int unsigned idxW     = clog2_min1(width * maxChunks),
  localparam int unsigned cntW     = clog2_min1(maxChunks + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] A_i,
  input  logic             last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             Z_o,
  output logic [idxW-1:0]  first_zero_o,
  output logic [cntW-1:0]  count_o,
  output logic             overflow_o
);

  localparam int unsigned posW = clog2_min1(width);
  // Reported index when the only zeros sat in beats past maxChunks.
  localparam logic [idxW-1:0] FZ_OVF   = idxW'(width * maxChunks - 1);
  localparam logic [cntW-1:0] CNT_MAX  = cntW'(maxChunks);

  state_t state, state_n;

  logic            acc;
  logic            found;
  logic [cntW-1:0] idx;
  logic [idxW-1:0] fz;
  logic            ovf;

  logic [posW-1:0] enc_pos;
  logic            enc_any;

  logic            accept;
  logic            release_res;
  logic            at_max;
  logic            take_fz;
  logic            acc_n;
  logic            found_n;
  logic [cntW-1:0] idx_n;
  logic [idxW-1:0] fz_n;
  logic            ovf_n;
  logic [idxW-1:0] fz_out;

  first_zero_enc #(.width(width)) u_enc (
    .a        (A_i),
    .pos      (enc_pos),
    .any_zero (enc_any)
  );

  assign accept      = in_valid_i & in_ready_o;
  assign release_res = out_valid_o & out_ready_i;

  // Next accumulator values if the current beat is taken.
  assign at_max  = (idx == CNT_MAX);
  assign take_fz = !found && enc_any && !at_max;
  assign acc_n   = acc & ~enc_any;
  assign found_n = found | take_fz;
  assign fz_n    = take_fz ? (idxW'(idx) * idxW'(width) + idxW'(enc_pos)) : fz;
  assign idx_n   = at_max ? idx : idx + cntW'(1);
  assign ovf_n   = ovf | at_max;
  assign fz_out  = acc_n ? '0 : (found_n ? fz_n : FZ_OVF);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ACCUM;
    else       state <= state_n;
  end

  // FSM next state and handshake outputs, decoded from the state register.
  always_comb begin
    state_n     = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i && last_i) state_n = HOLD;
      end
      HOLD: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_n = ACCUM;
      end
      default: state_n = ACCUM;
    endcase
  end

  // Frame accumulators and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc          <= 1'b1;
      found        <= 1'b0;
      idx          <= '0;
      fz           <= '0;
      ovf          <= 1'b0;
      Z_o          <= 1'b1;
      first_zero_o <= '0;
      count_o      <= '0;
      overflow_o   <= 1'b0;
    end else if (accept) begin
      acc   <= acc_n;
      found <= found_n;
      idx   <= idx_n;
      fz    <= fz_n;
      ovf   <= ovf_n;
      if (last_i) begin
        Z_o          <= acc_n;
        first_zero_o <= fz_out;
        count_o      <= idx_n;
        overflow_o   <= ovf_n;
      end
    end else if (release_res) begin
      acc   <= 1'b1;
      found <= 1'b0;
      idx   <= '0;
      fz    <= '0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_red_and.sv
// Bench for seq_red_and with width=8, maxChunks=4 (idxW=5, cntW=3).
module tb_seq_red_and;

  localparam int W  = 8;
  localparam int MC = 4;
  localparam int NFRAMES = 200;

  logic       clk_i;
  logic       rst_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] A_i;
  logic       last_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       Z_o;
  logic [4:0] first_zero_o;
  logic [2:0] count_o;
  logic       overflow_o;

  seq_red_and #(.width(W), .maxChunks(MC)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .A_i          (A_i),
    .last_i       (last_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .Z_o          (Z_o),
    .first_zero_o (first_zero_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // Result packing: {Z, first_zero[4:0], count[2:0], overflow}
  logic [9:0] exp_q[$];

  typedef struct {
    logic [5:0][7:0] beats;
    int              n;
    logic [9:0]      exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] res_now();
    return {Z_o, first_zero_o, count_o, overflow_o};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input int n,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                         input logic z, input logic [4:0] fz, input logic [2:0] c, input logic o);
    vec_t v;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2;
    v.beats[3] = b3; v.beats[4] = b4; v.beats[5] = b5;
    v.n   = n;
    v.exp = {z, fz, c, o};
    vecs.push_back(v);
  endtask

  // Reference model of one frame, written from the behavioural description.
  function automatic logic [9:0] model(input logic [5:0][7:0] b, input int n);
    logic       acc;
    logic       found;
    logic       ovf;
    int         idx;
    int         fz;
    logic [4:0] fzo;
    acc = 1'b1; found = 1'b0; ovf = 1'b0; idx = 0; fz = 0;
    for (int i = 0; i < n; i++) begin
      acc = acc & (&b[i]);
      if (!found && b[i] != 8'hFF && idx < MC) begin
        for (int j = W - 1; j >= 0; j--) if (!b[i][j]) fz = idx * W + j;
        found = 1'b1;
      end
      if (idx == MC) ovf = 1'b1;
      else idx++;
    end
    fzo = acc ? 5'd0 : (found ? 5'(fz) : 5'(W * MC - 1));
    return {acc, fzo, 3'(idx), ovf};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one beat after 'gap' idle cycles and returns right after the
  // clock edge that accepts it.
  task automatic drive_beat(input logic [7:0] b, input logic l, input int gap);
    int wait_cyc;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk_i);
      in_valid_i = 1'b0;
    end
    @(negedge clk_i);
    in_valid_i = 1'b1;
    A_i        = b;
    last_i     = l;
    wait_cyc   = 0;
    while (!in_ready_o && wait_cyc < 200) begin
      @(negedge clk_i);
      wait_cyc++;
    end
    check("in_ready_wait", {15'd0, in_ready_o}, 16'd1);
    check("valid_low_while_accum", {15'd0, out_valid_o}, 16'd0);
    @(posedge clk_i);
  endtask

  // Sends one table frame back-to-back, checks the result one cycle later,
  // then releases it with a single-cycle out_ready.
  task automatic apply_vec(input vec_t v, input string name);
    out_ready_i = 1'b0;
    for (int i = 0; i < v.n; i++) drive_beat(v.beats[i], (i == v.n - 1), 0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    last_i     = 1'b0;
    check({name, "_valid"}, {15'd0, out_valid_o}, 16'd1);
    check({name, "_result"}, {6'd0, res_now()}, {6'd0, v.exp});
    check({name, "_in_ready_low"}, {15'd0, in_ready_o}, 16'd0);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check({name, "_released"}, {14'd0, out_valid_o, in_ready_o}, 16'b01);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    int   rcv;
    int   cyc;

    rst_i = 1'b1; in_valid_i = 1'b0; A_i = '0; last_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset values.
    check("reset_handshake", {14'd0, in_ready_o, out_valid_o}, 16'b10);
    check("reset_result", {6'd0, res_now()}, {6'd0, 1'b1, 5'd0, 3'd0, 1'b0});

    // Directed table: hand-computed results.
    add_vec(1, 8'hFF, 0, 0, 0, 0, 0,                 1'b1, 5'd0,  3'd1, 1'b0);
    add_vec(3, 8'hFF, 8'hEF, 8'h00, 0, 0, 0,         1'b0, 5'd12, 3'd3, 1'b0);
    add_vec(5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 0, 1'b0, 5'd31, 3'd4, 1'b1);
    add_vec(6, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 5'd0, 3'd4, 1'b1);
    add_vec(5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1'b1, 5'd0,  3'd4, 1'b1);
    add_vec(4, 8'hFF, 8'hFF, 8'hFF, 8'h80, 0, 0,     1'b0, 5'd24, 3'd4, 1'b0);
    add_vec(2, 8'hF0, 8'h0F, 0, 0, 0, 0,             1'b0, 5'd0,  3'd2, 1'b0);
    add_vec(2, 8'hFF, 8'hFF, 0, 0, 0, 0,             1'b1, 5'd0,  3'd2, 1'b0);
    add_vec(3, 8'hFF, 8'h7F, 8'hFF, 0, 0, 0,         1'b0, 5'd15, 3'd3, 1'b0);
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held for 5 stalled cycles.
    out_ready_i = 1'b0;
    drive_beat(8'h7F, 1'b1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      in_valid_i = 1'b0;
      check("stall_result", {6'd0, res_now()}, {6'd0, 1'b0, 5'd7, 3'd1, 1'b0});
      check("stall_handshake", {14'd0, in_ready_o, out_valid_o}, 16'b01);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check("stall_release", {14'd0, in_ready_o, out_valid_o}, 16'b10);

    // Reset mid-frame: partial frame discarded.
    drive_beat(8'h00, 1'b0, 0);
    drive_beat(8'h00, 1'b0, 0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midframe_rst_handshake", {14'd0, in_ready_o, out_valid_o}, 16'b10);
    repeat (2) begin
      @(negedge clk_i);
      check("midframe_rst_no_result", {15'd0, out_valid_o}, 16'd0);
    end
    v.beats = '0; v.beats[0] = 8'hFF; v.n = 1; v.exp = {1'b1, 5'd0, 3'd1, 1'b0};
    apply_vec(v, "after_midframe_rst");

    // Reset while holding a result: pending result dropped.
    drive_beat(8'h00, 1'b1, 0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    check("hold_before_rst", {15'd0, out_valid_o}, 16'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("hold_rst_handshake", {14'd0, in_ready_o, out_valid_o}, 16'b10);
    check("hold_rst_result", {6'd0, res_now()}, {6'd0, 1'b1, 5'd0, 3'd0, 1'b0});

    // Random traffic with input gaps and output stalls.
    rcv = 0;
    cyc = 0;
    fork
      begin : producer
        logic [5:0][7:0] b;
        int n;
        for (int f = 0; f < NFRAMES; f++) begin
          n = $urandom_range(1, MC + 1);
          b = '0;
          for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
              0, 1:    b[i] = 8'hFF;
              2:       b[i] = ~(8'd1 << $urandom_range(0, 7));
              default: b[i] = 8'($urandom_range(0, 255));
            endcase
          end
          exp_q.push_back(model(b, n));
          for (int i = 0; i < n; i++) drive_beat(b[i], (i == n - 1), $urandom_range(0, 2));
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
      end
      begin : consumer
        logic [9:0] e;
        while (rcv < NFRAMES && cyc < 30000) begin
          @(negedge clk_i);
          cyc++;
          out_ready_i = ($urandom_range(0, 3) != 0);
          if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
              check("rand_unexpected_result", 16'd1, 16'd0);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("rand_frame%0d", rcv), {6'd0, res_now()}, {6'd0, e});
            end
            rcv++;
          end
        end
        out_ready_i = 1'b0;
      end
    join
    check("rand_frames_received", 16'(rcv), 16'(NFRAMES));
    check("rand_queue_empty", 16'(exp_q.size()), 16'd0);

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
